// File: rtl/volume_request_arbiter_if.sv
// Volume-side request/ack signals and firmware-facing command signals of the
// volume request arbiter, bundled for the arbiter (slave) and its driver (master).
interface volume_request_arbiter_if;
   logic [1:0]       vol_ready;
   logic [1:0]       vol_rd;
   logic [1:0]       vol_wr;
   logic [1:0][31:0] vol_lba;
   logic [1:0][5:0]  vol_blk_cnt;
   logic [1:0]       vol_ack;
   logic             cmd_valid;
   logic             cmd_vol;
   logic             cmd_wr;
   logic [31:0]      cmd_lba;
   logic [5:0]       cmd_blk_cnt;
   logic             cmd_done;
   logic             busy;
   logic             timeout_err;
   logic             err_clr;

   modport slave (
      input  vol_ready, vol_rd, vol_wr, vol_lba, vol_blk_cnt, cmd_done, err_clr,
      output vol_ack, cmd_valid, cmd_vol, cmd_wr, cmd_lba, cmd_blk_cnt, busy, timeout_err
   );

   modport master (
      output vol_ready, vol_rd, vol_wr, vol_lba, vol_blk_cnt, cmd_done, err_clr,
      input  vol_ack, cmd_valid, cmd_vol, cmd_wr, cmd_lba, cmd_blk_cnt, busy, timeout_err
   );
endinterface

// File: rtl/volume_request_arbiter.sv
// Round-robin arbiter presenting one volume block-I/O command at a time to firmware.
// Optional outstanding-command timeout enabled by defining VOLUME_ARB_TIMEOUT_EN.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no command outstanding, arbitrating eligible volumes
// S_GRANT | latched command presented to firmware, awaiting cmd_done
// S_ACK   | ack held to granted volume until it drops rd and wr
module volume_request_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 27_000_000
) (
   input logic                      clk,
   input logic                      reset,
   volume_request_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_ACK} state_t;

   state_t      state_q, state_d;
   logic        last_grant_q, last_grant_d;
   logic        cmd_vol_q, cmd_vol_d;
   logic        cmd_wr_q, cmd_wr_d;
   logic [31:0] cmd_lba_q, cmd_lba_d;
   logic [5:0]  cmd_blk_cnt_q, cmd_blk_cnt_d;

   logic [1:0]  elig;
   logic        pick;
   logic        gnt_active;
   logic        gnt_released;
   logic        timeout_hit;

   assign elig         = bus.vol_ready & (bus.vol_rd | bus.vol_wr);
   // On a tie the volume opposite the previous winner goes next.
   assign pick         = (elig == 2'b11) ? ~last_grant_q : elig[1];
   assign gnt_released = ~(bus.vol_rd[cmd_vol_q] | bus.vol_wr[cmd_vol_q]);
   assign gnt_active   = bus.vol_ready[cmd_vol_q] & ~gnt_released;

   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      cmd_vol_d     = cmd_vol_q;
      cmd_wr_d      = cmd_wr_q;
      cmd_lba_d     = cmd_lba_q;
      cmd_blk_cnt_d = cmd_blk_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (|elig) begin
               cmd_vol_d     = pick;
               cmd_wr_d      = bus.vol_wr[pick];
               cmd_lba_d     = bus.vol_lba[pick];
               cmd_blk_cnt_d = bus.vol_blk_cnt[pick];
               last_grant_d  = pick;
               state_d       = S_GRANT;
            end
         end
         S_GRANT: begin
            // Requester withdrawal beats a coincident completion.
            if (!gnt_active)
               state_d = S_IDLE;
            else if (bus.cmd_done || timeout_hit)
               state_d = S_ACK;
         end
         S_ACK: begin
            if (gnt_released)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         last_grant_q  <= 1'b1;
         cmd_vol_q     <= 1'b0;
         cmd_wr_q      <= 1'b0;
         cmd_lba_q     <= '0;
         cmd_blk_cnt_q <= '0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         cmd_vol_q     <= cmd_vol_d;
         cmd_wr_q      <= cmd_wr_d;
         cmd_lba_q     <= cmd_lba_d;
         cmd_blk_cnt_q <= cmd_blk_cnt_d;
      end
   end

`ifdef VOLUME_ARB_TIMEOUT_EN
   localparam logic [31:0] TC_LAST = TIMEOUT_CYCLES - 32'd1;

   logic [31:0] cnt_q, cnt_d;
   logic        err_q, err_d;

   assign timeout_hit = (cnt_q == TC_LAST);

   always_comb begin
      cnt_d = (state_q == S_GRANT) ? cnt_q + 32'd1 : '0;
      err_d = err_q;
      if (bus.err_clr)
         err_d = 1'b0;
      // Forced completion: leaving GRANT for ACK without a firmware strobe.
      if (state_q == S_GRANT && state_d == S_ACK && !bus.cmd_done)
         err_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign bus.timeout_err = err_q;
`else
   logic unused_cfg;

   assign timeout_hit     = 1'b0;
   assign unused_cfg      = bus.err_clr ^ (TIMEOUT_CYCLES == 0);
   assign bus.timeout_err = 1'b0;
`endif

   assign bus.cmd_valid   = (state_q == S_GRANT);
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.vol_ack     = (state_q != S_ACK) ? 2'b00 : (cmd_vol_q ? 2'b10 : 2'b01);
   assign bus.cmd_vol     = cmd_vol_q;
   assign bus.cmd_wr      = cmd_wr_q;
   assign bus.cmd_lba     = cmd_lba_q;
   assign bus.cmd_blk_cnt = cmd_blk_cnt_q;

endmodule
